// File: rtl/output_display_if.sv
// output_display_if: bus between the CPU output-register side and the display.
//
// Macro: none (the optional leading-zero blanking feature lives in output_display.sv).
//
// Signals:
//   oi           : output-register load strobe from control (master -> slave)
//   data_i[7:0]  : CPU bus byte (master -> slave)
//   sgn          : 1 = byte is two's complement, 0 = unsigned (master -> slave)
//   display_data : latched raw byte (slave -> master)
//   busy         : decimal conversion in progress (slave -> master)
//   seg[6:0]     : segments {g,f,e,d,c,b,a}, active-high (slave -> master)
//   dig[3:0]     : one-hot digit enable, [0]=ones .. [3]=sign (slave -> master)
//   dbg_state    : conversion FSM state, 0 = idle, 1 = converting (slave -> master)
//
// Handshake: oi is a valid-only strobe with no ready. A load is taken on
// every rising edge where oi=1, including while busy, in which case the new
// byte replaces the conversion in flight. busy is status only and never
// stalls the master.
interface output_display_if;
  logic       oi;
  logic [7:0] data_i;
  logic       sgn;
  logic [7:0] display_data;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] dig;
  logic       dbg_state;

  modport master (
    output oi, data_i, sgn,
    input  display_data, busy, seg, dig, dbg_state
  );

  modport slave (
    input  oi, data_i, sgn,
    output display_data, busy, seg, dig, dbg_state
  );
endinterface

// File: rtl/output_display.sv
// output_display: latches the CPU output byte, converts it to sign + three
// decimal digits with a sequential double-dabble engine (one bit per clock),
// and drives a 4-digit multiplexed 7-segment display.
//
// Parameters:
//   SCAN_DIV : clock cycles each digit stays enabled (>= 2).
// Configuration macro:
//   DISPLAY_LZB_EN : when defined, leading zeros in hundreds/tens are blanked.
// Ports:
//   clk : system clock
//   clr : synchronous active-high reset
//   bus : output_display_if.slave (oi, data_i, sgn in; display_data, busy,
//         seg, dig, dbg_state out)
module output_display #(
  parameter int SCAN_DIV = 1024
) (
  input logic             clk,
  input logic             clr,
  output_display_if.slave bus
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] P_TERM = PW'(SCAN_DIV - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]    r_disp_data;
  logic [7:0]    r_m;
  logic          r_n;
  logic [11:0]   r_bcd;
  logic [3:0]    r_step;
  logic [3:0]    r_h, r_t, r_o;
  logic          r_neg;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;

  logic [11:0]   w_bcd_adj;
  logic [11:0]   w_bcd_shift;
  logic [6:0]    w_seg;

  function automatic logic [6:0] f_seg7(input logic [3:0] v);
    case (v)
      4'd0:    f_seg7 = 7'h3F;
      4'd1:    f_seg7 = 7'h06;
      4'd2:    f_seg7 = 7'h5B;
      4'd3:    f_seg7 = 7'h4F;
      4'd4:    f_seg7 = 7'h66;
      4'd5:    f_seg7 = 7'h6D;
      4'd6:    f_seg7 = 7'h7D;
      4'd7:    f_seg7 = 7'h07;
      4'd8:    f_seg7 = 7'h7F;
      4'd9:    f_seg7 = 7'h6F;
      default: f_seg7 = 7'h00;
    endcase
  endfunction

  function automatic logic [3:0] f_adj(input logic [3:0] v);
    f_adj = (v >= 4'd5) ? v + 4'd3 : v;
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // A load always (re)starts a conversion; the 8th iteration returns to idle.
  always_comb begin
    w_next = r_state;
    if (bus.oi)
      w_next = S_CONV;
    else if (r_state == S_CONV && r_step == 4'd7)
      w_next = S_IDLE;
  end

  // One double-dabble iteration: add 3 to nibbles >= 5, then shift in the
  // next magnitude bit (MSB first).
  always_comb begin
    w_bcd_adj   = {f_adj(r_bcd[11:8]), f_adj(r_bcd[7:4]), f_adj(r_bcd[3:0])};
    w_bcd_shift = {w_bcd_adj[10:0], r_m[7]};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_disp_data <= 8'h00;
      r_m         <= 8'h00;
      r_n         <= 1'b0;
      r_bcd       <= 12'h000;
      r_step      <= 4'd0;
      r_h         <= 4'd0;
      r_t         <= 4'd0;
      r_o         <= 4'd0;
      r_neg       <= 1'b0;
    end else if (bus.oi) begin
      r_disp_data <= bus.data_i;
      // Negating 0x80 in 8 bits yields 0x80, which read unsigned is 128.
      r_m         <= (bus.sgn && bus.data_i[7]) ? (~bus.data_i + 8'd1) : bus.data_i;
      r_n         <= bus.sgn && bus.data_i[7];
      r_bcd       <= 12'h000;
      r_step      <= 4'd0;
    end else if (r_state == S_CONV) begin
      r_bcd  <= w_bcd_shift;
      r_m    <= {r_m[6:0], 1'b0};
      r_step <= r_step + 4'd1;
      // Display registers only move here, so the panel never shows a
      // half-converted value.
      if (r_step == 4'd7) begin
        r_h   <= w_bcd_shift[11:8];
        r_t   <= w_bcd_shift[7:4];
        r_o   <= w_bcd_shift[3:0];
        r_neg <= r_n;
      end
    end
  end

  // Digit scan, free-running and independent of loads.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (r_presc == P_TERM) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_comb begin
    w_seg = 7'h00;
    case (r_idx)
      2'd0: w_seg = f_seg7(r_o);
`ifdef DISPLAY_LZB_EN
      2'd1: w_seg = (r_h == 4'd0 && r_t == 4'd0) ? 7'h00 : f_seg7(r_t);
      2'd2: w_seg = (r_h == 4'd0) ? 7'h00 : f_seg7(r_h);
`else
      2'd1: w_seg = f_seg7(r_t);
      2'd2: w_seg = f_seg7(r_h);
`endif
      2'd3: w_seg = r_neg ? 7'h40 : 7'h00;
      default: w_seg = 7'h00;
    endcase
  end

  assign bus.display_data = r_disp_data;
  assign bus.busy         = (r_state == S_CONV);
  assign bus.dbg_state    = r_state;
  assign bus.seg          = w_seg;
  assign bus.dig          = 4'b0001 << r_idx;

endmodule
